// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: one 2-entry FIFO per functional unit, round-robin
// grant of up to PRF_WR_COUNT FIFO heads per cycle onto registered PRF write ports.

// Per-producer 2-entry FIFO. Ready comes only from the registered count, so a
// same-cycle dequeue never frees a slot for the current offer.
module prf_wb_fifo #(
  parameter int LOG_PR_COUNT = 7
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enq,
  input  logic [31:0]             enq_data,
  input  logic [LOG_PR_COUNT-1:0] enq_pr,
  input  logic                    deq,
  output logic                    ready,
  output logic                    nonempty,
  output logic [31:0]             head_data,
  output logic [LOG_PR_COUNT-1:0] head_pr
);
  typedef struct packed {
    logic [LOG_PR_COUNT-1:0] pr;
    logic [31:0]             data;
  } ent_t;

  ent_t       mem [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;

  assign ready     = (count < 2'd2);
  assign nonempty  = (count != 2'd0);
  assign head_data = mem[rd_ptr].data;
  assign head_pr   = mem[rd_ptr].pr;

  // Pointer/count bookkeeping; enq and deq in the same cycle leave count alone.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is not counted.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= '{pr: enq_pr, data: enq_data};
  end
endmodule

module prf_wb_arbiter #(
  parameter int FU_COUNT     = 4,
  parameter int PRF_WR_COUNT = 2,
  parameter int LOG_PR_COUNT = 7
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic [FU_COUNT-1:0]                         fu_valid_by_fu,
  output logic [FU_COUNT-1:0]                         fu_ready_by_fu,
  input  logic [FU_COUNT-1:0][31:0]                   fu_data_by_fu,
  input  logic [FU_COUNT-1:0][LOG_PR_COUNT-1:0]       fu_PR_by_fu,
  output logic [PRF_WR_COUNT-1:0]                     WB_valid_by_wr,
  output logic [PRF_WR_COUNT-1:0][31:0]               WB_data_by_wr,
  output logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   WB_PR_by_wr
);
  localparam int FU_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
  localparam int CW   = $clog2(PRF_WR_COUNT + 1);

  logic [FU_COUNT-1:0]                    enq, grant, nonempty;
  logic [FU_COUNT-1:0][31:0]              head_data;
  logic [FU_COUNT-1:0][LOG_PR_COUNT-1:0]  head_pr;

  logic [FU_W-1:0]                        rr_ptr, rr_nxt, idx, last_idx;
  logic [FU_W:0]                          sum, nxt;
  logic [CW-1:0]                          cnt;
  logic [PRF_WR_COUNT-1:0]                port_vld;
  logic [PRF_WR_COUNT-1:0][FU_W-1:0]      port_sel;

  // PR 0 offers are accepted (ready honoured) but dropped instead of enqueued.
  for (genvar g = 0; g < FU_COUNT; g++) begin : g_fu
    assign enq[g] = fu_valid_by_fu[g] & fu_ready_by_fu[g] & (fu_PR_by_fu[g] != '0);

    prf_wb_fifo #(.LOG_PR_COUNT(LOG_PR_COUNT)) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .enq       (enq[g]),
      .enq_data  (fu_data_by_fu[g]),
      .enq_pr    (fu_PR_by_fu[g]),
      .deq       (grant[g]),
      .ready     (fu_ready_by_fu[g]),
      .nonempty  (nonempty[g]),
      .head_data (head_data[g]),
      .head_pr   (head_pr[g])
    );
  end

  // Round-robin scan from rr_ptr; the k-th nonempty FIFO found drives port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_sel = '0;
    cnt      = '0;
    last_idx = '0;
    idx      = '0;
    sum      = '0;
    nxt      = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      sum = {1'b0, rr_ptr} + (FU_W+1)'(i);
      if (sum >= (FU_W+1)'(FU_COUNT)) sum = sum - (FU_W+1)'(FU_COUNT);
      idx = sum[FU_W-1:0];
      if (nonempty[idx] && (cnt < CW'(PRF_WR_COUNT))) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < PRF_WR_COUNT; k++) begin
          if (cnt == CW'(k)) begin
            port_vld[k] = 1'b1;
            port_sel[k] = idx;
          end
        end
        cnt      = cnt + CW'(1);
        last_idx = idx;
      end
    end
    nxt = {1'b0, last_idx} + (FU_W+1)'(1);
    if (nxt >= (FU_W+1)'(FU_COUNT)) nxt = '0;
    rr_nxt = nxt[FU_W-1:0];
  end

  // Pointer moves past the last FU served; it holds when nothing was granted.
  always_ff @(posedge CLK) begin
    if (RST)         rr_ptr <= '0;
    else if (|grant) rr_ptr <= rr_nxt;
  end

  // Registered write ports; valid clears on reset so in-flight work is dropped.
  always_ff @(posedge CLK) begin
    if (RST) WB_valid_by_wr <= '0;
    else     WB_valid_by_wr <= port_vld;
  end

  // Payload capture of the granted heads; only meaningful when valid.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < PRF_WR_COUNT; k++) begin
      WB_data_by_wr[k] <= head_data[port_sel[k]];
      WB_PR_by_wr[k]   <= head_pr[port_sel[k]];
    end
  end
endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Randomized bench for prf_wb_arbiter with a queue-based reference model.
module tb_prf_wb_arbiter;
  localparam int F = 4;
  localparam int W = 2;
  localparam int P = 7;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [F-1:0]          fu_valid_by_fu;
  logic [F-1:0]          fu_ready_by_fu;
  logic [F-1:0][31:0]    fu_data_by_fu;
  logic [F-1:0][P-1:0]   fu_PR_by_fu;
  logic [W-1:0]          WB_valid_by_wr;
  logic [W-1:0][31:0]    WB_data_by_wr;
  logic [W-1:0][P-1:0]   WB_PR_by_wr;

  prf_wb_arbiter #(.FU_COUNT(F), .PRF_WR_COUNT(W), .LOG_PR_COUNT(P)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .fu_valid_by_fu (fu_valid_by_fu),
    .fu_ready_by_fu (fu_ready_by_fu),
    .fu_data_by_fu  (fu_data_by_fu),
    .fu_PR_by_fu    (fu_PR_by_fu),
    .WB_valid_by_wr (WB_valid_by_wr),
    .WB_data_by_wr  (WB_data_by_wr),
    .WB_PR_by_wr    (WB_PR_by_wr)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each producer is a queue of at most two pending writes.
  typedef struct {
    logic [31:0]  d;
    logic [P-1:0] pr;
  } ent_t;

  ent_t         mq [F][$];
  int           rr;
  logic [W-1:0] e_vld;
  logic [31:0]  e_data [W];
  logic [P-1:0] e_pr   [W];

  // Fairness bookkeeping, taken from what the DUT actually emits.
  bit fair_on;
  int cyc;
  int fcnt [F];
  int last_seen [F];
  int max_gap [F];

  task automatic model_step(input bit rst);
    logic [F-1:0] rdy;
    int n, f, last;
    for (int i = 0; i < F; i++) rdy[i] = (mq[i].size() < 2);
    if (rst) begin
      for (int i = 0; i < F; i++) mq[i].delete();
      rr    = 0;
      e_vld = '0;
      return;
    end
    e_vld = '0;
    n     = 0;
    last  = -1;
    for (int i = 0; i < F; i++) begin
      f = (rr + i) % F;
      if (mq[f].size() > 0 && n < W) begin
        e_vld[n]  = 1'b1;
        e_data[n] = mq[f][0].d;
        e_pr[n]   = mq[f][0].pr;
        void'(mq[f].pop_front());
        n++;
        last = f;
      end
    end
    if (last >= 0) rr = (last + 1) % F;
    for (int i = 0; i < F; i++)
      if (fu_valid_by_fu[i] && rdy[i] && fu_PR_by_fu[i] != '0)
        mq[i].push_back('{d: fu_data_by_fu[i], pr: fu_PR_by_fu[i]});
  endtask

  // One clock: check ready against the model, advance both, check WB ports.
  task automatic cycle(input bit rst);
    logic [F-1:0] rdy;
    int f, gap;
    RST = rst;
    for (int i = 0; i < F; i++) rdy[i] = (mq[i].size() < 2);
    chk("fu_ready", 64'(fu_ready_by_fu), 64'(rdy));
    model_step(rst);
    @(posedge CLK);
    #1;
    cyc++;
    chk("wb_valid", 64'(WB_valid_by_wr), 64'(e_vld));
    for (int w = 0; w < W; w++) begin
      if (e_vld[w]) begin
        chk($sformatf("wb_data%0d", w), 64'(WB_data_by_wr[w]), 64'(e_data[w]));
        chk($sformatf("wb_pr%0d", w), 64'(WB_PR_by_wr[w]), 64'(e_pr[w]));
      end
    end
    if (fair_on) begin
      for (int w = 0; w < W; w++) begin
        if (WB_valid_by_wr[w]) begin
          f = int'(WB_data_by_wr[w][31:28]);
          if (f < F) begin
            gap = cyc - last_seen[f];
            if (gap > max_gap[f]) max_gap[f] = gap;
            last_seen[f] = cyc;
            fcnt[f]++;
          end
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    fu_valid_by_fu = '0;
    fu_data_by_fu  = '0;
    fu_PR_by_fu    = '0;
  endtask

  task automatic offer(input int f, input logic [P-1:0] pr, input logic [31:0] d);
    fu_valid_by_fu[f] = 1'b1;
    fu_PR_by_fu[f]    = pr;
    fu_data_by_fu[f]  = d;
  endtask

  bit saw_bp;
  int seq;

  initial begin
    idle();
    rr    = 0;
    e_vld = '0;
    cyc   = 0;
    fair_on = 1'b0;
    RST   = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    // Reset state: FIFOs empty, no writes.
    chk("reset_ready", 64'(fu_ready_by_fu), 64'hF);
    chk("reset_valid", 64'(WB_valid_by_wr), 64'h0);

    // Single write from FU1: visible after the second edge.
    cycle(1'b1);
    offer(1, 7'd5, 32'hDEADBEEF);
    cycle(1'b0);
    idle();
    chk("single_early", 64'(WB_valid_by_wr), 64'h0);
    cycle(1'b0);
    chk("single_vld", 64'(WB_valid_by_wr), 64'h1);
    chk("single_pr", 64'(WB_PR_by_wr[0]), 64'd5);
    chk("single_data", 64'(WB_data_by_wr[0]), 64'hDEADBEEF);
    cycle(1'b0);
    chk("single_idle", 64'(WB_valid_by_wr), 64'h0);

    // Contention: four simultaneous offers, drained two per cycle in FU order.
    cycle(1'b1);
    for (int f = 0; f < F; f++) offer(f, 7'(10 + f), 32'(f));
    cycle(1'b0);
    idle();
    cycle(1'b0);
    chk("cont1_vld", 64'(WB_valid_by_wr), 64'h3);
    chk("cont1_pr0", 64'(WB_PR_by_wr[0]), 64'd10);
    chk("cont1_pr1", 64'(WB_PR_by_wr[1]), 64'd11);
    cycle(1'b0);
    chk("cont2_vld", 64'(WB_valid_by_wr), 64'h3);
    chk("cont2_pr0", 64'(WB_PR_by_wr[0]), 64'd12);
    chk("cont2_pr1", 64'(WB_PR_by_wr[1]), 64'd13);
    cycle(1'b0);
    // rr_ptr is back at 0: a lone FU3 then FU0 offer must come out FU0 first.
    offer(0, 7'd20, 32'h0);
    offer(3, 7'd23, 32'h3);
    cycle(1'b0);
    idle();
    cycle(1'b0);
    chk("rr_wrap_pr0", 64'(WB_PR_by_wr[0]), 64'd20);
    chk("rr_wrap_pr1", 64'(WB_PR_by_wr[1]), 64'd23);

    // PR zero is consumed and never written back.
    cycle(1'b1);
    offer(2, 7'd0, 32'hBAD);
    chk("pr0_ready", 64'(fu_ready_by_fu[2]), 64'h1);
    cycle(1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0);
      chk("pr0_none", 64'(WB_valid_by_wr), 64'h0);
    end

    // Backpressure on FU0 with every other FU saturating.
    saw_bp = 1'b0;
    seq    = 1;
    for (int i = 0; i < 40; i++) begin
      for (int f = 1; f < F; f++) offer(f, 7'($urandom_range(1, 127)), $urandom);
      offer(0, 7'(((seq - 1) % 127) + 1), 32'(seq));
      if (!fu_ready_by_fu[0]) saw_bp = 1'b1;
      if (fu_ready_by_fu[0]) seq++;
      cycle(1'b0);
    end
    chk("bp_seen", 64'(saw_bp), 64'h1);

    // Reset mid-stream with entries queued.
    for (int f = 0; f < 3; f++) offer(f, 7'(30 + f), $urandom);
    cycle(1'b0);
    cycle(1'b0);
    idle();
    cycle(1'b1);
    chk("midrst_vld", 64'(WB_valid_by_wr), 64'h0);
    chk("midrst_rdy", 64'(fu_ready_by_fu), 64'hF);
    cycle(1'b0);
    chk("midrst_after", 64'(WB_valid_by_wr), 64'h0);

    // Fairness: four producers offering continuously.
    cycle(1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int f = 0; f < F; f++) offer(f, 7'($urandom_range(1, 127)), {4'(f), 28'($urandom)});
      cycle(1'b0);
    end
    for (int f = 0; f < F; f++) begin
      fcnt[f]      = 0;
      max_gap[f]   = 0;
      last_seen[f] = cyc;
    end
    fair_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      for (int f = 0; f < F; f++) offer(f, 7'($urandom_range(1, 127)), {4'(f), 28'($urandom)});
      cycle(1'b0);
    end
    fair_on = 1'b0;
    for (int f = 0; f < F; f++) begin
      chk($sformatf("fair_cnt%0d", f), 64'(fcnt[f] >= 49 && fcnt[f] <= 51), 64'h1);
      chk($sformatf("fair_gap%0d", f), 64'(max_gap[f] <= 2), 64'h1);
    end

    // Random traffic with PR zeros, duplicate PRs and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      for (int f = 0; f < F; f++) begin
        fu_valid_by_fu[f] = ($urandom_range(0, 2) != 0);
        fu_PR_by_fu[f]    = 7'($urandom_range(0, 7));
        fu_data_by_fu[f]  = $urandom;
      end
      cycle($urandom_range(0, 49) == 0);
    end
    idle();
    for (int i = 0; i < 4; i++) cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
